hamming_seq_ctrl: RTL and testbench
===================================

Name: hamming_seq_ctrl

Overview:
- Hardware sequencer for program 1: walks NUM_MSG 11-bit messages stored as byte pairs in data memory.
- Computes each message's (16,11) SECDED Hamming block and writes it back as byte pairs.
- Sits beside the core on the data-memory port; top level asserts start and observes done.
- Owns the memory port only while busy; top-level mux grants the port on busy.

Parameters:
- NUM_MSG, 15, number of messages processed per run (1..255).
- SRC_BASE, 0, byte address of message 0 low byte.
- DST_BASE, 30, byte address of encoded block 0 low byte.
- AW, 8, memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
- busy  out  1  high while a run is in progress; port-ownership grant.
- done  out  1  level; high from run completion until next start or reset.
- mem_addr  out  AW  data-memory byte address.
- mem_wr_en  out  1  write strobe; memory writes mem_wr_data at rising edge.
- mem_wr_data  out  8  write byte.
- mem_rd_data  in  8  read byte; valid one cycle after mem_addr presented (1-cycle read latency).
- msg_idx  out  8  index of message currently being processed.

Behaviour:
- Reset values: busy=0, done=0, mem_addr=0, mem_wr_en=0, mem_wr_data=0, msg_idx=0; state=IDLE. Reset mid-run aborts immediately; no further writes are issued.
- States: IDLE, RDL, RDH, CAP, WRL, WRH, DONE.
- IDLE: start=1 -> RDL, msg_idx=0, busy=1.
- RDL: mem_addr=SRC_BASE+2*i -> RDH.
- RDH: mem_addr=SRC_BASE+2*i+1; lo<=mem_rd_data -> CAP.
- CAP: hi<=mem_rd_data[2:0]; mem_rd_data[7:3] ignored -> WRL.
- WRL: mem_addr=DST_BASE+2*i, mem_wr_en=1, mem_wr_data=enc[7:0] -> WRH.
- WRH: mem_addr=DST_BASE+2*i+1, mem_wr_en=1, mem_wr_data=enc[15:8]. If i==NUM_MSG-1 -> DONE; else i++ and -> RDL.
- DONE: busy=0, done=1, mem_wr_en=0. Stays in DONE until start=1, which clears done and -> RDL with i=0.
- start while busy: ignored, no restart.
- mem_wr_en is high only in WRL/WRH. mem_addr and mem_wr_data are registered Moore outputs. Exactly 2*NUM_MSG writes per run.
- Latency: 5 cycles per message. done rises 5*NUM_MSG+1 cycles after the start edge (76 for the default).
- Encoding, with d[11:1]={hi[2:0],lo}:
  - p8=^d[11:5].
  - p4=^d[11:8]^^d[4:2].
  - p2=d11^d10^d7^d6^d4^d3^d1.
  - p1=d11^d9^d7^d5^d4^d2^d1.
  - p0=^d^p8^p4^p2^p1.
  - enc={d[11:5],p8,d[4:2],p4,d1,p2,p1,p0}.
- Address arithmetic is modulo 2^AW; wrap is legal and unchecked.
- Source and destination regions must not overlap; behaviour when they do is undefined.

Test Plan:
- Message 0 lo=0x00 hi=0x00, NUM_MSG=1, pulse start -> byte[30]=0x00, byte[31]=0x00, done high at cycle 6, exactly 2 writes.
- Message lo=0xFF hi=0x07 -> enc=0xFFFF (byte[30]=0xFF, byte[31]=0xFF); lo=0x01 hi=0x00 -> enc=0x000F; lo=0x00 hi=0x04 -> enc=0x8117.
- Full default run, 15 random messages with hi[7:3] garbage -> all 30 output bytes match the reference formula; done rises at cycle 76; busy high cycles 1-75; msg_idx steps 0..14.
- start re-pulsed at cycle 20 of a run -> ignored: identical outputs, done still at 76. start pulsed in DONE -> done drops next cycle, second run completes identically.
- Assert reset at cycle 12 of a run (message 2 mid-read) -> all outputs 0 asynchronously, no further writes, bytes 34+ untouched. A subsequent start yields a clean full run.
- NUM_MSG=1, SRC_BASE=250, DST_BASE=254, AW=8 -> reads 250/251, writes 254/255, correct enc, done after 6 cycles.

Source files
------------

// File: rtl/hamming_seq_ctrl.sv
// Data-memory sequencer: reads 11-bit messages stored as byte pairs, builds the
// (16,11) SECDED Hamming block for each and writes it back as a byte pair.
module hamming_seq_ctrl #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    input  logic [7:0]    mem_rd_data,
    output logic [7:0]    msg_idx
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RDL  = 3'd1;
    localparam logic [2:0] S_RDH  = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_WRL  = 3'd4;
    localparam logic [2:0] S_WRH  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [AW-1:0] SRC0     = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST0     = AW'(DST_BASE);
    localparam logic [7:0]    LAST_IDX = 8'(NUM_MSG - 1);

    logic [2:0]    state;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [7:0]    lo;
    logic [7:0]    enc_hi;
    logic [15:0]   enc;

    // d[11:1] = {hi[2:0], lo}; parity bits sit at Hamming positions 1,2,4,8,
    // p0 is the overall parity that upgrades SEC to SECDED.
    function automatic logic [15:0] hamming_enc(input logic [10:0] d_in);
        logic [11:1] d;
        logic        p8, p4, p2, p1, p0;
        d  = d_in;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

    // High byte arrives on the read port during CAP, so encode straight from it.
    assign enc = hamming_enc({mem_rd_data[2:0], lo});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= 8'd0;
            msg_idx     <= 8'd0;
            src_ptr     <= SRC0;
            dst_ptr     <= DST0;
            lo          <= 8'd0;
            enc_hi      <= 8'd0;
        end else begin
            mem_wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_RDL;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        msg_idx  <= 8'd0;
                        src_ptr  <= SRC0;
                        dst_ptr  <= DST0;
                        mem_addr <= SRC0;
                    end
                end
                S_RDL: begin
                    mem_addr <= src_ptr + AW'(1);
                    state    <= S_RDH;
                end
                S_RDH: begin
                    lo    <= mem_rd_data;
                    state <= S_CAP;
                end
                S_CAP: begin
                    mem_addr    <= dst_ptr;
                    mem_wr_en   <= 1'b1;
                    mem_wr_data <= enc[7:0];
                    enc_hi      <= enc[15:8];
                    state       <= S_WRL;
                end
                S_WRL: begin
                    mem_addr    <= dst_ptr + AW'(1);
                    mem_wr_en   <= 1'b1;
                    mem_wr_data <= enc_hi;
                    state       <= S_WRH;
                end
                S_WRH: begin
                    if (msg_idx == LAST_IDX) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        msg_idx  <= msg_idx + 8'd1;
                        src_ptr  <= src_ptr + AW'(2);
                        dst_ptr  <= dst_ptr + AW'(2);
                        mem_addr <= src_ptr + AW'(2);
                        state    <= S_RDL;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
// Directed bench for hamming_seq_ctrl: three instances (default, single message,
// address wrap) each with its own byte memory having a 1-cycle read latency.
module tb_hamming_seq_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic [7:0] addr_a, addr_b, addr_c;
    logic       we_a, we_b, we_c;
    logic [7:0] wd_a, wd_b, wd_c;
    logic [7:0] rd_a = 8'd0, rd_b = 8'd0, rd_c = 8'd0;
    logic [7:0] idx_a, idx_b, idx_c;

    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];
    logic [7:0] mem_c [0:255];
    int wcnt_a = 0, wcnt_b = 0, wcnt_c = 0;

    logic       ld_we = 1'b0;
    int         ld_sel = 0;
    logic [7:0] ld_addr = 8'd0;
    logic [7:0] ld_data = 8'd0;

    int nvec = 0;
    int nmis = 0;

    logic [7:0] lo_v [0:14];
    logic [7:0] hi_v [0:14];
    logic       busy_h [0:127];
    logic       done_h [0:127];
    logic [7:0] idx_h  [0:127];

    hamming_seq_ctrl dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_addr(addr_a), .mem_wr_en(we_a), .mem_wr_data(wd_a),
        .mem_rd_data(rd_a), .msg_idx(idx_a)
    );

    hamming_seq_ctrl #(.NUM_MSG(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_addr(addr_b), .mem_wr_en(we_b), .mem_wr_data(wd_b),
        .mem_rd_data(rd_b), .msg_idx(idx_b)
    );

    hamming_seq_ctrl #(.NUM_MSG(1), .SRC_BASE(250), .DST_BASE(254), .AW(8)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .busy(busy_c), .done(done_c),
        .mem_addr(addr_c), .mem_wr_en(we_c), .mem_wr_data(wd_c),
        .mem_rd_data(rd_c), .msg_idx(idx_c)
    );

    always @(posedge clk) begin
        if (ld_we && ld_sel == 0) mem_a[ld_addr] <= ld_data;
        else if (we_a) begin
            mem_a[addr_a] <= wd_a;
            wcnt_a <= wcnt_a + 1;
        end
        rd_a <= mem_a[addr_a];
    end

    always @(posedge clk) begin
        if (ld_we && ld_sel == 1) mem_b[ld_addr] <= ld_data;
        else if (we_b) begin
            mem_b[addr_b] <= wd_b;
            wcnt_b <= wcnt_b + 1;
        end
        rd_b <= mem_b[addr_b];
    end

    always @(posedge clk) begin
        if (ld_we && ld_sel == 2) mem_c[ld_addr] <= ld_data;
        else if (we_c) begin
            mem_c[addr_c] <= wd_c;
            wcnt_c <= wcnt_c + 1;
        end
        rd_c <= mem_c[addr_c];
    end

    // Positional Hamming reference: data fills non-power-of-two positions 3..15,
    // parity bit at position b covers every position with bit b set.
    function automatic logic [15:0] ref_enc(input logic [7:0] lo, input logic [7:0] hi);
        logic [10:0] d;
        logic [15:0] c;
        int k;
        d = {hi[2:0], lo};
        c = '0;
        k = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[k];
                k++;
            end
        end
        for (int b = 1; b < 16; b = b * 2) begin
            logic x;
            x = 1'b0;
            for (int p = 1; p < 16; p++) if ((p & b) != 0) x = x ^ c[p];
            c[b] = x;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    function automatic logic cur_busy(input int sel);
        return (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
    endfunction

    function automatic logic cur_done(input int sel);
        return (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
    endfunction

    function automatic logic [7:0] cur_idx(input int sel);
        return (sel == 0) ? idx_a : (sel == 1) ? idx_b : idx_c;
    endfunction

    task automatic load(input int sel, input int addr, input logic [7:0] data);
        ld_sel  = sel;
        ld_addr = 8'(addr);
        ld_data = data;
        ld_we   = 1'b1;
        @(negedge clk);
        ld_we   = 1'b0;
    endtask

    task automatic clear_dst(input int sel, input int base, input int n);
        for (int a = 0; a < n; a++) load(sel, base + a, 8'hA5);
    endtask

    // Cycle c is the interval after the c-th rising edge; edge 1 samples start.
    task automatic run(input int sel, input int repulse, input int stop_at, output int done_cyc);
        done_cyc = -1;
        set_start(sel, 1'b1);
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (c == 1 || c == repulse + 1) set_start(sel, 1'b0);
            if (c == repulse) set_start(sel, 1'b1);
            busy_h[c] = cur_busy(sel);
            done_h[c] = cur_done(sel);
            idx_h[c]  = cur_idx(sel);
            if (done_h[c] === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (c == stop_at) break;
        end
    endtask

    task automatic check_a_blocks(input string tag, input int nmsg);
        for (int k = 0; k < nmsg; k++) begin
            logic [15:0] e;
            e = ref_enc(lo_v[k], hi_v[k]);
            check($sformatf("%s_m%0d_lo", tag, k), 32'(mem_a[30 + 2 * k]), 32'(e[7:0]));
            check($sformatf("%s_m%0d_hi", tag, k), 32'(mem_a[31 + 2 * k]), 32'(e[15:8]));
        end
    endtask

    task automatic check_full_run(input string tag, input int dc, input int wc0);
        int bad;
        check({tag, "_done_cyc"}, 32'(dc), 32'd76);
        check({tag, "_wr_count"}, 32'(wcnt_a - wc0), 32'd30);
        bad = 0;
        for (int c = 1; c <= 75; c++) if (busy_h[c] !== 1'b1) bad++;
        check({tag, "_busy_low_cycles"}, 32'(bad), 32'd0);
        if (dc == 76) check({tag, "_busy_at_done"}, 32'(busy_h[76]), 32'd0);
        for (int k = 0; k < 15; k++)
            check($sformatf("%s_idx_c%0d", tag, 5 * k + 3), 32'(idx_h[5 * k + 3]), 32'(k));
        check_a_blocks(tag, 15);
    endtask

    task automatic b_vec(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                         input logic [15:0] exp);
        int dc, wc0;
        load(1, 0, lo);
        load(1, 1, hi);
        clear_dst(1, 30, 2);
        wc0 = wcnt_b;
        run(1, -1, -1, dc);
        check({tag, "_done_cyc"}, 32'(dc), 32'd6);
        check({tag, "_wr_count"}, 32'(wcnt_b - wc0), 32'd2);
        check({tag, "_byte30"}, 32'(mem_b[30]), 32'(exp[7:0]));
        check({tag, "_byte31"}, 32'(mem_b[31]), 32'(exp[15:8]));
    endtask

    initial begin
        int dc, wc0, bad;
        logic [15:0] e;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_addr", 32'(addr_a), 32'd0);
        check("rst_wr_en", 32'(we_a), 32'd0);
        check("rst_wr_data", 32'(wd_a), 32'd0);
        check("rst_msg_idx", 32'(idx_a), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single-message directed vectors; 0xFC carries garbage in hi[7:3].
        b_vec("zero", 8'h00, 8'h00, 16'h0000);
        for (int c = 1; c <= 5; c++) check($sformatf("zero_busy_c%0d", c), 32'(busy_h[c]), 32'd1);
        b_vec("ones", 8'hFF, 8'h07, 16'hFFFF);
        b_vec("d1", 8'h01, 8'h00, 16'h000F);
        b_vec("d11", 8'h00, 8'hFC, 16'h8117);

        // Address wrap instance: reads 250/251, writes 254/255.
        load(2, 250, 8'hA5);
        load(2, 251, 8'h03);
        load(2, 0, 8'h00);
        load(2, 1, 8'h00);
        clear_dst(2, 254, 2);
        wc0 = wcnt_c;
        run(2, -1, -1, dc);
        e = ref_enc(8'hA5, 8'h03);
        check("wrap_done_cyc", 32'(dc), 32'd6);
        check("wrap_wr_count", 32'(wcnt_c - wc0), 32'd2);
        check("wrap_byte254", 32'(mem_c[254]), 32'(e[7:0]));
        check("wrap_byte255", 32'(mem_c[255]), 32'(e[15:8]));

        // Full default run with random payload and garbage in hi[7:3].
        for (int k = 0; k < 15; k++) begin
            lo_v[k] = 8'($urandom);
            hi_v[k] = {5'($urandom) | 5'b00001, 3'($urandom)};
            load(0, 2 * k, lo_v[k]);
            load(0, 2 * k + 1, hi_v[k]);
        end
        clear_dst(0, 30, 30);
        wc0 = wcnt_a;
        run(0, -1, -1, dc);
        check_full_run("run1", dc, wc0);

        // Restart from DONE, with a stray start re-pulsed mid-run.
        clear_dst(0, 30, 30);
        wc0 = wcnt_a;
        run(0, 20, -1, dc);
        check("run2_done_drop", 32'(done_h[1]), 32'd0);
        check_full_run("run2", dc, wc0);

        // Abort in cycle 12 (message 2 mid-read).
        clear_dst(0, 30, 30);
        wc0 = wcnt_a;
        run(0, -1, 12, dc);
        check("abort_reached_c12", 32'(dc), 32'hFFFF_FFFF);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        check("abort_addr", 32'(addr_a), 32'd0);
        check("abort_wr_en", 32'(we_a), 32'd0);
        check("abort_wr_data", 32'(wd_a), 32'd0);
        check("abort_msg_idx", 32'(idx_a), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_wr_count", 32'(wcnt_a - wc0), 32'd4);
        check_a_blocks("abort", 2);
        bad = 0;
        for (int a = 34; a < 60; a++) if (mem_a[a] !== 8'hA5) bad++;
        check("abort_untouched", 32'(bad), 32'd0);
        check("abort_idle_busy", 32'(busy_a), 32'd0);

        // Clean run after the abort.
        clear_dst(0, 30, 30);
        wc0 = wcnt_a;
        run(0, -1, -1, dc);
        check_full_run("run3", dc, wc0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
